bpfcap_dma: RTL and testbench



---
 rtl/bpfcap_pkg.sv | 28 ++
 rtl/bpfcap_csr.sv | 72 +++++++
 rtl/bpfcap_dma.sv | 146 ++++++++++++++
 tb/tb_bpfcap_dma.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bpfcap_pkg.sv
// Shared constants and types for the BPF capture copy engine.
package bpfcap_pkg;

    // CSR word indices on the s0 slave
    localparam logic [2:0] CSR_CTRL  = 3'd0;
    localparam logic [2:0] CSR_BEGIN = 3'd1;
    localparam logic [2:0] CSR_END   = 3'd2;
    localparam logic [2:0] CSR_DST   = 3'd3;
    localparam logic [2:0] CSR_CNT   = 3'd4;

    // Bit positions inside the control register
    localparam int CTRL_GO   = 0;
    localparam int CTRL_BUSY = 1;
    localparam int CTRL_DONE = 2;

    // Every bus transfer is a single beat
    localparam logic [15:0] BURST_ONE = 16'd1;

    // Copy FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RWAIT,
        ST_WR,
        ST_FIN
    } state_t;

endpackage

// File: rtl/bpfcap_csr.sv
// CSR block: s0 decode, register file, registered readback and GO pulse.
module bpfcap_csr
    import bpfcap_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic              busy,
    input  logic              done,
    input  logic [DATA_W-1:0] word_count,
    output logic              go,
    output logic              ctrl_wr,
    output logic [ADDR_W-1:0] pkt_begin,
    output logic [ADDR_W-1:0] pkt_end,
    output logic [ADDR_W-1:0] dst_addr
);

    logic [DATA_W-1:0] rd_mux;

    // Any control write clears DONE; GO only launches a run from idle
    assign ctrl_wr = write && (address == CSR_CTRL);
    assign go      = ctrl_wr && writedata[CTRL_GO] && !busy;

    // Readback mux; unmapped indices and GO read as zero
    always_comb begin
        rd_mux = '0;
        case (address)
            CSR_CTRL: begin
                rd_mux[CTRL_BUSY] = busy;
                rd_mux[CTRL_DONE] = done;
            end
            CSR_BEGIN: rd_mux = DATA_W'(pkt_begin);
            CSR_END:   rd_mux = DATA_W'(pkt_end);
            CSR_DST:   rd_mux = DATA_W'(dst_addr);
            CSR_CNT:   rd_mux = word_count;
            default:   rd_mux = '0;
        endcase
    end

    // Address registers, frozen while a run is in progress; low two bits forced 0
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_begin <= '0;
            pkt_end   <= '0;
            dst_addr  <= '0;
        end else if (write && !busy) begin
            case (address)
                CSR_BEGIN: pkt_begin <= {writedata[ADDR_W-1:2], 2'b00};
                CSR_END:   pkt_end   <= {writedata[ADDR_W-1:2], 2'b00};
                CSR_DST:   dst_addr  <= {writedata[ADDR_W-1:2], 2'b00};
                default:   ;
            endcase
        end
    end

    // Registered readback, held until the next read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: rtl/bpfcap_dma.sv
// Packet-capture copy engine: reads a buffer over m0, writes each word over m1.
// Bus handshake: there is no waitrequest; a strobe held for one cycle is a
// complete transfer, and m0 read data is valid exactly one cycle after the
// cycle in which avs_m0_read was high.
module bpfcap_dma
    import bpfcap_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [DATA_W-1:0] avs_s0_writedata,
    output logic [DATA_W-1:0] avs_s0_readdata,
    output logic [ADDR_W-1:0] avs_m0_address,
    output logic              avs_m0_read,
    output logic [15:0]       avs_m0_burstcount,
    input  logic [DATA_W-1:0] avs_m0_readdata,
    output logic [ADDR_W-1:0] avs_m1_address,
    output logic              avs_m1_write,
    output logic [15:0]       avs_m1_burstcount,
    output logic [DATA_W-1:0] avs_m1_writedata
);

    state_t            state;
    state_t            state_next;
    logic              busy;
    logic              done_q;
    logic              go;
    logic              ctrl_wr;
    logic [ADDR_W-1:0] pkt_begin;
    logic [ADDR_W-1:0] pkt_end;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] cur_inc;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] word_count;

    bpfcap_csr #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_csr (
        .clk        (clk),
        .reset      (reset),
        .address    (avs_s0_address),
        .read       (avs_s0_read),
        .write      (avs_s0_write),
        .writedata  (avs_s0_writedata),
        .readdata   (avs_s0_readdata),
        .busy       (busy),
        .done       (done_q),
        .word_count (word_count),
        .go         (go),
        .ctrl_wr    (ctrl_wr),
        .pkt_begin  (pkt_begin),
        .pkt_end    (pkt_end),
        .dst_addr   (dst_addr)
    );

    // BUSY spans GO through the FIN cycle
    assign busy    = (state != ST_IDLE);
    assign cur_inc = cur + ADDR_W'(4);

    assign avs_m0_burstcount = BURST_ONE;
    assign avs_m1_burstcount = BURST_ONE;
    assign avs_m0_address    = cur;
    assign avs_m1_address    = dst;
    assign avs_m1_writedata  = data_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus strobes; strobes decode from state so reset drops them at once
    always_comb begin
        state_next   = state;
        avs_m0_read  = 1'b0;
        avs_m1_write = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_next = (pkt_end <= pkt_begin) ? ST_FIN : ST_RD;
                end
            end
            ST_RD: begin
                avs_m0_read = 1'b1;
                state_next  = ST_RWAIT;
            end
            ST_RWAIT: state_next = ST_WR;
            ST_WR: begin
                avs_m1_write = 1'b1;
                state_next   = (cur_inc >= pkt_end) ? ST_FIN : ST_RD;
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Copy datapath: pointers, captured word and word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= '0;
            dst        <= '0;
            data_q     <= '0;
            word_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        cur        <= pkt_begin;
                        dst        <= dst_addr;
                        word_count <= '0;
                    end
                end
                ST_RWAIT: data_q <= avs_m0_readdata;
                ST_WR: begin
                    cur        <= cur_inc;
                    dst        <= dst + ADDR_W'(4);
                    word_count <= word_count + DATA_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Sticky DONE: set on run completion, cleared by any control write
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else if (state == ST_FIN) begin
            done_q <= 1'b1;
        end else if (ctrl_wr) begin
            done_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bpfcap_dma.sv
// Directed bench for bpfcap_dma: CSR vector table plus copy-run sequences.
module tb_bpfcap_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  s0_address;
    logic        s0_read;
    logic        s0_write;
    logic [31:0] s0_writedata;
    logic [31:0] s0_readdata;
    logic [31:0] m0_address;
    logic        m0_read;
    logic [15:0] m0_burstcount;
    logic [31:0] m0_readdata = '0;
    logic [31:0] m1_address;
    logic        m1_write;
    logic [15:0] m1_burstcount;
    logic [31:0] m1_writedata;

    int n_compared = 0;
    int n_failed   = 0;
    int cyc        = 0;

    // Monitor queues
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[16];

    bpfcap_dma dut (
        .clk               (clk),
        .reset             (reset),
        .avs_s0_address    (s0_address),
        .avs_s0_read       (s0_read),
        .avs_s0_write      (s0_write),
        .avs_s0_writedata  (s0_writedata),
        .avs_s0_readdata   (s0_readdata),
        .avs_m0_address    (m0_address),
        .avs_m0_read       (m0_read),
        .avs_m0_burstcount (m0_burstcount),
        .avs_m0_readdata   (m0_readdata),
        .avs_m1_address    (m1_address),
        .avs_m1_write      (m1_write),
        .avs_m1_burstcount (m1_burstcount),
        .avs_m1_writedata  (m1_writedata)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read slave model: word at 0x20+4i holds 10+i, returned one cycle later
    always @(posedge clk) begin
        if (m0_read) m0_readdata <= 32'd10 + ((m0_address - 32'h20) >> 2);
    end

    // Bus monitor sampled on the falling edge
    always @(negedge clk) begin
        if (m0_read) begin
            rd_addr_q.push_back(m0_address);
            rd_cyc_q.push_back(cyc);
        end
        if (m1_write) begin
            wr_addr_q.push_back(m1_address);
            wr_data_q.push_back(m1_writedata);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [2:0] idx, input logic [31:0] data);
        @(negedge clk);
        s0_address   = idx;
        s0_writedata = data;
        s0_write     = 1'b1;
        @(negedge clk);
        s0_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] idx, output logic [31:0] data);
        @(negedge clk);
        s0_address = idx;
        s0_read    = 1'b1;
        @(negedge clk);
        s0_read    = 1'b0;
        data       = s0_readdata;
    endtask

    task automatic clear_mon();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    // Poll control until DONE, bounded
    task automatic wait_done(input string name);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 60; i++) begin
            csr_read(3'd0, v);
            if (v[2]) break;
        end
        check(name, {31'd0, v[2]}, 32'd1);
    endtask

    // Compare an 8-word run against the expected copy
    task automatic check_run(input string tag);
        check({tag, "_nrd"}, rd_addr_q.size(), 32'd8);
        check({tag, "_nwr"}, wr_addr_q.size(), 32'd8);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'd10 + i);
        for (int i = 0; i < 8 && i < rd_addr_q.size() && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_rdaddr%0d", tag, i), rd_addr_q[i], 32'h20 + 4 * i);
            check($sformatf("%s_wraddr%0d", tag, i), wr_addr_q[i], 32'h100 + 4 * i);
            check($sformatf("%s_wrdata%0d", tag, i), wr_data_q[i], exp_q.pop_front());
            check($sformatf("%s_lat%0d", tag, i), wr_cyc_q[i] - rd_cyc_q[i], 32'd2);
        end
    endtask

    initial begin
        logic [31:0] v;
        reset        = 1'b1;
        s0_address   = '0;
        s0_read      = 1'b0;
        s0_write     = 1'b0;
        s0_writedata = '0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_read", {31'd0, m0_read}, 32'd0);
        check("rst_m1_write", {31'd0, m1_write}, 32'd0);
        check("rst_readdata", s0_readdata, 32'd0);
        check("rst_m1_wdata", m1_writedata, 32'd0);
        check("m0_burst", {16'd0, m0_burstcount}, 32'd1);
        check("m1_burst", {16'd0, m1_burstcount}, 32'd1);
        reset = 1'b0;

        // CSR table: reset values, R/W, low-bit masking, unmapped indices
        tbl[0]  = '{1'b0, 3'd0, 32'd0, 32'd0};
        tbl[1]  = '{1'b0, 3'd1, 32'd0, 32'd0};
        tbl[2]  = '{1'b0, 3'd2, 32'd0, 32'd0};
        tbl[3]  = '{1'b0, 3'd3, 32'd0, 32'd0};
        tbl[4]  = '{1'b0, 3'd4, 32'd0, 32'd0};
        tbl[5]  = '{1'b1, 3'd1, 32'h23, 32'd0};
        tbl[6]  = '{1'b0, 3'd1, 32'd0, 32'h20};
        tbl[7]  = '{1'b1, 3'd2, 32'h40, 32'd0};
        tbl[8]  = '{1'b1, 3'd3, 32'h100, 32'd0};
        tbl[9]  = '{1'b0, 3'd2, 32'd0, 32'h40};
        tbl[10] = '{1'b0, 3'd3, 32'd0, 32'h100};
        tbl[11] = '{1'b1, 3'd6, 32'hdead_beef, 32'd0};
        tbl[12] = '{1'b0, 3'd6, 32'd0, 32'd0};
        tbl[13] = '{1'b1, 3'd4, 32'h55, 32'd0};
        tbl[14] = '{1'b0, 3'd4, 32'd0, 32'd0};
        tbl[15] = '{1'b0, 3'd7, 32'd0, 32'd0};
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) begin
                csr_write(tbl[i].idx, tbl[i].wdata);
            end else begin
                csr_read(tbl[i].idx, v);
                check($sformatf("csr_vec%0d_idx%0d", i, tbl[i].idx), v, tbl[i].exp);
            end
        end

        // Copy 8 words
        clear_mon();
        csr_write(3'd0, 32'd1);
        wait_done("copy_done");
        check_run("copy");
        csr_read(3'd4, v);
        check("copy_count", v, 32'd8);
        csr_read(3'd0, v);
        check("copy_ctrl", v, 32'h4);

        // Empty range: begin == end
        csr_write(3'd1, 32'h40);
        clear_mon();
        csr_write(3'd0, 32'd1);
        csr_read(3'd0, v);
        check("empty_ctrl", v, 32'h4);
        csr_read(3'd4, v);
        check("empty_count", v, 32'd0);
        repeat (4) @(negedge clk);
        check("empty_nrd", rd_addr_q.size(), 32'd0);
        check("empty_nwr", wr_addr_q.size(), 32'd0);

        // Busy protection: writes to pkt_end and GO during a run are ignored
        csr_write(3'd1, 32'h20);
        clear_mon();
        csr_write(3'd0, 32'd1);
        csr_read(3'd0, v);
        check("busy_flag", v, 32'h2);
        csr_write(3'd2, 32'h80);
        csr_write(3'd0, 32'd1);
        wait_done("busy_done");
        repeat (6) @(negedge clk);
        check_run("busy");
        csr_read(3'd2, v);
        check("busy_end", v, 32'h40);

        // Reset mid-run after the third word
        clear_mon();
        csr_write(3'd0, 32'd1);
        for (int i = 0; i < 40 && wr_addr_q.size() < 3; i++) @(negedge clk);
        check("mid_3words", wr_addr_q.size(), 32'd3);
        // This negedge is the WR cycle of word 3; without reset the next cycle reads
        reset = 1'b1;
        @(negedge clk);
        check("mid_m0_read", {31'd0, m0_read}, 32'd0);
        check("mid_m1_write", {31'd0, m1_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            csr_read(3'(i), v);
            check($sformatf("mid_csr%0d", i), v, 32'd0);
        end
        check("mid_nwr", wr_addr_q.size(), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule
